// File: rtl/rb_pkg.sv
// Shared defaults, requester indices and retire-entry type for the Retire Bus arbiter.
package rb_pkg;

    localparam int unsigned RB_NREQ   = 4;
    localparam int unsigned RB_TAG_W  = 5;
    localparam int unsigned RB_DATA_W = 32;

    localparam int unsigned RB_ALU  = 0;
    localparam int unsigned RB_MULT = 1;
    localparam int unsigned RB_DIV  = 2;
    localparam int unsigned RB_LS   = 3;

    typedef struct packed {
        logic [RB_TAG_W-1:0]  tag;
        logic [RB_DATA_W-1:0] data;
    } rb_entry_t;

    // Next round-robin position after index idx, wrapping n-1 back to 0.
    function automatic int unsigned rb_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rb_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr (mod NREQ).
module rb_rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // Walking the rotated order directly is the rotate/encode/unrotate in one pass.
    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[PTR_W'(j)]) begin
                any                = 1'b1;
                grant[PTR_W'(j)]   = 1'b1;
                idx                = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/retire_bus_arbiter.sv
// Round-robin arbiter sharing the Retire Bus among completing units; registers the winner.
// Optional per-requester grant counters are built when RB_PERF_CNT_EN is defined.
module retire_bus_arbiter
    import rb_pkg::*;
#(
    parameter int unsigned NREQ   = RB_NREQ,
    parameter int unsigned TAG_W  = RB_TAG_W,
    parameter int unsigned DATA_W = RB_DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*TAG_W-1:0]    req_tag,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_grant,
    input  logic                     tagFifo_full,
    input  logic                     flush,
    output logic [TAG_W-1:0]         RB_Tag,
    output logic [DATA_W-1:0]        RB_Data,
    output logic                     RB_Tag_Valid,
    output logic [NREQ*CNT_W-1:0]    perf_cnt
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  pick_idx;
    logic [NREQ-1:0]   pick_grant;
    logic              pick_any;
    logic              grant_en;
    logic              granted;
    logic [TAG_W-1:0]  tag_arr  [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign tag_arr[g]  = req_tag[g*TAG_W +: TAG_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rb_rr_pick #(
        .NREQ (NREQ),
        .PTR_W(PTR_W)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(pick_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Reset is folded in so no requester sees a grant while the bus is held in reset.
    assign grant_en  = !reset && !tagFifo_full && !flush;
    assign req_grant = grant_en ? pick_grant : '0;
    assign granted   = grant_en && pick_any;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RB_Tag       <= '0;
            RB_Data      <= '0;
            RB_Tag_Valid <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            RB_Tag_Valid <= granted;
            if (granted) begin
                RB_Tag  <= tag_arr[pick_idx];
                RB_Data <= data_arr[pick_idx];
                rr_ptr  <= PTR_W'(rb_wrap_inc(32'(pick_idx), NREQ));
            end
        end
    end

`ifdef RB_PERF_CNT_EN
    logic [CNT_W-1:0] cnt [NREQ];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NREQ; k++) cnt[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (req_grant[k] && cnt[k] != '1) cnt[k] <= cnt[k] + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_perf
        assign perf_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_retire_bus_arbiter.sv
// Table-driven bench with a retire scoreboard for retire_bus_arbiter (NREQ=4, CNT_W=2).
module tb_retire_bus_arbiter;
    import rb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_grant;
    logic            tagFifo_full;
    logic            flush;
    logic [TW-1:0]   RB_Tag;
    logic [DW-1:0]   RB_Data;
    logic            RB_Tag_Valid;
    logic [N*CW-1:0] perf_cnt;

    retire_bus_arbiter #(
        .NREQ  (N),
        .TAG_W (TW),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_data    (req_data),
        .req_grant   (req_grant),
        .tagFifo_full(tagFifo_full),
        .flush       (flush),
        .RB_Tag      (RB_Tag),
        .RB_Data     (RB_Data),
        .RB_Tag_Valid(RB_Tag_Valid),
        .perf_cnt    (perf_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           rst;
        logic [N-1:0] v;
        bit           full;
        bit           fl;
        logic [N-1:0] g;
    } vec_t;

    vec_t        tbl [23];
    rb_entry_t   sb_q [$];
    int unsigned seq [N];
    int unsigned pcnt [N];
    logic [TW-1:0] last_tag;
    logic [DW-1:0] last_data;
    int checks   = 0;
    int failures = 0;

    function automatic logic [TW-1:0] tag_of(input int unsigned i);
        return TW'(i * 8 + seq[i] + 7);
    endfunction

    function automatic logic [DW-1:0] data_of(input int unsigned i);
        return 32'hCAFE + (32'(i) << 16) + 32'(seq[i]) * 32'h101;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_payload();
        for (int i = 0; i < N; i++) begin
            req_tag[i*TW +: TW]  = tag_of(i);
            req_data[i*DW +: DW] = data_of(i);
        end
    endtask

    task automatic check_perf(input string name);
        logic [CW-1:0] got;
        logic [CW-1:0] exp;
        for (int i = 0; i < N; i++) begin
            got = perf_cnt[i*CW +: CW];
`ifdef RB_PERF_CNT_EN
            exp = CW'(pcnt[i]);
`else
            exp = '0;
`endif
            check($sformatf("%s_perf%0d", name, i), 64'(got), 64'(exp));
        end
    endtask

    task automatic clear_model();
        sb_q.delete();
        last_tag  = '0;
        last_data = '0;
        for (int i = 0; i < N; i++) pcnt[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", 64'(RB_Tag_Valid), 64'd0);
        check("rst_tag",   64'(RB_Tag),       64'd0);
        check("rst_data",  64'(RB_Data),      64'd0);
        check("rst_grant", 64'(req_grant),    64'd0);
        clear_model();
        check_perf("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Compare the retire registers one posedge after each step against the scoreboard.
    task automatic check_rb(input int n);
        rb_entry_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("v%0d_rb_valid", n), 64'(RB_Tag_Valid), 64'd1);
            check($sformatf("v%0d_rb_tag", n),   64'(RB_Tag),       64'(e.tag));
            check($sformatf("v%0d_rb_data", n),  64'(RB_Data),      64'(e.data));
            last_tag  = e.tag;
            last_data = e.data;
        end else begin
            check($sformatf("v%0d_rb_valid", n), 64'(RB_Tag_Valid), 64'd0);
            check($sformatf("v%0d_rb_tag_hold", n),  64'(RB_Tag),  64'(last_tag));
            check($sformatf("v%0d_rb_data_hold", n), 64'(RB_Data), 64'(last_data));
        end
    endtask

    task automatic run_vec(input vec_t t, input int n);
        int w;
        if (t.rst) do_reset();
        req_valid    = t.v;
        tagFifo_full = t.full;
        flush        = t.fl;
        drive_payload();
        #4;
        check($sformatf("v%0d_grant", n), 64'(req_grant), 64'(t.g));
        w = -1;
        for (int i = 0; i < N; i++) if (t.g[i]) w = i;
        if (w >= 0) begin
            sb_q.push_back('{tag: tag_of(w), data: data_of(w)});
            seq[w]++;
            if (pcnt[w] < (1 << CW) - 1) pcnt[w]++;
        end
        @(posedge clock);
        #1;
        check_rb(n);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_tag      = '0;
        req_data     = '0;
        tagFifo_full = 1'b0;
        flush        = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        clear_model();

        //          rst  valid    full fl  grant
        tbl[0]  = '{1, 4'b0001, 0, 0, 4'b0001};
        tbl[1]  = '{1, 4'b1111, 0, 0, 4'b0001};
        tbl[2]  = '{0, 4'b1111, 0, 0, 4'b0010};
        tbl[3]  = '{0, 4'b1111, 0, 0, 4'b0100};
        tbl[4]  = '{0, 4'b1111, 0, 0, 4'b1000};
        tbl[5]  = '{0, 4'b1111, 0, 0, 4'b0001};
        tbl[6]  = '{0, 4'b1111, 0, 0, 4'b0010};
        tbl[7]  = '{0, 4'b1111, 0, 0, 4'b0100};
        tbl[8]  = '{0, 4'b1111, 0, 0, 4'b1000};
        tbl[9]  = '{0, 4'b0100, 0, 0, 4'b0100};
        tbl[10] = '{0, 4'b1001, 0, 0, 4'b1000};
        tbl[11] = '{0, 4'b1001, 0, 0, 4'b0001};
        tbl[12] = '{0, 4'b0100, 1, 0, 4'b0000};
        tbl[13] = '{0, 4'b0100, 1, 0, 4'b0000};
        tbl[14] = '{0, 4'b0100, 1, 0, 4'b0000};
        tbl[15] = '{0, 4'b0100, 0, 0, 4'b0100};
        tbl[16] = '{0, 4'b0010, 1, 1, 4'b0000};
        tbl[17] = '{0, 4'b0010, 0, 1, 4'b0000};
        tbl[18] = '{0, 4'b0010, 0, 0, 4'b0010};
        tbl[19] = '{0, 4'b0010, 0, 1, 4'b0000};
        tbl[20] = '{0, 4'b0000, 0, 0, 4'b0000};
        tbl[21] = '{0, 4'b0010, 0, 0, 4'b0010};
        tbl[22] = '{0, 4'b0010, 0, 0, 4'b0010};

        @(posedge clock);
        #1;
        for (int n = 0; n < 23; n++) run_vec(tbl[n], n);

        // Requester 1 has now been granted five times since the last reset.
        check_perf("sat");

        // Asynchronous reset in the middle of a burst drops the in-flight result.
        run_vec('{0, 4'b1111, 0, 0, 4'b0100}, 23);
        req_valid = 4'b1111;
        drive_payload();
        #2;
        check("burst_grant", 64'(req_grant), 64'b1000);
        reset = 1'b1;
        #1;
        check("async_valid", 64'(RB_Tag_Valid), 64'd0);
        check("async_tag",   64'(RB_Tag),       64'd0);
        check("async_data",  64'(RB_Data),      64'd0);
        check("async_grant", 64'(req_grant),    64'd0);
        clear_model();
        check_perf("async");
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_vec('{0, 4'b1111, 0, 0, 4'b0001}, 24);
        run_vec('{0, 4'b1111, 0, 0, 4'b0010}, 25);
        req_valid = '0;
        @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
